// File: rtl/button_pkg.sv
// button_pkg: shared hold-state type and counter sizing helper for the button debouncer array.
package button_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} hold_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_debouncer_array_channel.sv
// button_channel: one button lane with synchroniser, tick-based debounce and hold/repeat FSM.
module button_channel
    import button_pkg::*;
#(
    parameter int ACTIVE_HIGH  = 1,
    parameter int DEB_TICKS    = 2,
    parameter int HOLD_TICKS   = 800,
    parameter int REPEAT_TICKS = 150
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o,
    output logic press_next_o
);

    localparam int DW = $clog2(DEB_TICKS + 1);
    localparam int HW = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS) + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_TICKS > 0 ? REPEAT_TICKS - 1 : 0);
    localparam logic REP_EN = REPEAT_TICKS > 0;
    localparam logic INV    = ACTIVE_HIGH == 0;

    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    hold_state_t   state_q, state_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          s, accept, hold_done, rep_done, cnt_en;

    always_comb begin
        sync_d    = {sync_q[0], btn_raw};
        s         = sync_q[1] ^ INV;
        accept    = (s != level_q) && tick && (dcnt_q == DEB_LAST);
        dcnt_d    = (s == level_q || accept) ? '0 : dcnt_q + DW'(tick);
        level_d   = accept ? s : level_q;
        press_d   = accept && s;
        release_d = accept && !s;
        hold_done = (state_q == HOLD) && tick && (hcnt_q == HOLD_LAST);
        rep_done  = (state_q == REPEAT) && REP_EN && tick && (hcnt_q == REP_LAST);
        // A release accepted on an expiry tick swallows the long/repeat pulse.
        long_d    = hold_done && !release_d;
        repeat_d  = rep_done && !release_d;
        state_d   = release_d ? IDLE : press_d ? HOLD : hold_done ? REPEAT : state_q;
        cnt_en    = (state_q == HOLD) || ((state_q == REPEAT) && REP_EN);
        hcnt_d    = (release_d || press_d || hold_done || rep_done) ? '0 :
                    cnt_en ? hcnt_q + HW'(tick) : hcnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            state_q   <= IDLE;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            state_q   <= state_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign long_o       = long_q;
    assign repeat_o     = repeat_q;
    assign press_next_o = press_d;

endmodule

// File: rtl/button_debouncer_array.sv
// button_debouncer_array: shared-prescaler multi-channel debouncer with press/release/long/repeat events.
module button_debouncer_array
    import button_pkg::*;
#(
    parameter int N_CH         = 5,
    parameter int ACTIVE_HIGH  = 1,
    parameter int TICK_DIV     = 50000,
    parameter int DEB_TICKS    = 2,
    parameter int HOLD_TICKS   = 800,
    parameter int REPEAT_TICKS = 150
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_repeat,
    output logic            any_press
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]   pcnt_q, pcnt_d;
    logic            any_press_q, any_press_d;
    logic            tick;
    logic [N_CH-1:0] press_next;

    always_comb begin
        tick        = pcnt_q == P_LAST;
        pcnt_d      = tick ? '0 : pcnt_q + PW'(1);
        // Built from the channels' next-state so it lines up with btn_press.
        any_press_d = |press_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q      <= '0;
            any_press_q <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            any_press_q <= any_press_d;
        end
    end

    assign any_press = any_press_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        button_channel #(
            .ACTIVE_HIGH (ACTIVE_HIGH),
            .DEB_TICKS   (DEB_TICKS),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .tick        (tick),
            .btn_raw     (btn_in[i]),
            .level_o     (btn_level[i]),
            .press_o     (btn_press[i]),
            .release_o   (btn_release[i]),
            .long_o      (btn_long[i]),
            .repeat_o    (btn_repeat[i]),
            .press_next_o(press_next[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer_array.sv
// tb_button_debouncer_array: scoreboard bench; an active-high and an active-low DUT must match the same expected events.
module tb_button_debouncer_array;

    localparam int N = 3, TD = 4, DEB = 3, HOLD = 5, REP = 2;
    localparam int LONG_CLK = HOLD * TD;
    localparam int REP_CLK  = REP * TD;

    typedef struct {
        int          at;
        logic [12:0] ev;
        string       tag;
    } exp_t;

    logic         clk, rst;
    logic [N-1:0] btn, btn_n;
    logic [N-1:0] lvl, prs, rel, lng, rpt;
    logic [N-1:0] lvl_n, prs_n, rel_n, lng_n, rpt_n;
    logic         anyp, anyp_n;
    logic [12:0]  obs, obs_n, want;
    logic [15:0]  all_out, all_out_n;
    logic [N-1:0] exp_lvl;
    exp_t         q[$];
    exp_t         ex;
    string        tag;
    int           n, passed, total;

    assign btn_n     = ~btn;
    assign all_out   = {lvl, anyp, rpt, lng, rel, prs};
    assign all_out_n = {lvl_n, anyp_n, rpt_n, lng_n, rel_n, prs_n};

    button_debouncer_array #(
        .N_CH(N), .ACTIVE_HIGH(1), .TICK_DIV(TD), .DEB_TICKS(DEB),
        .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
    ) dut (
        .clk(clk), .reset(rst), .btn_in(btn), .btn_level(lvl), .btn_press(prs),
        .btn_release(rel), .btn_long(lng), .btn_repeat(rpt), .any_press(anyp)
    );

    button_debouncer_array #(
        .N_CH(N), .ACTIVE_HIGH(0), .TICK_DIV(TD), .DEB_TICKS(DEB),
        .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP)
    ) dut_n (
        .clk(clk), .reset(rst), .btn_in(btn_n), .btn_level(lvl_n), .btn_press(prs_n),
        .btn_release(rel_n), .btn_long(lng_n), .btn_repeat(rpt_n), .any_press(anyp_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edges since reset release; prescaler ticks take effect on edges that are multiples of TD.
    always @(posedge clk) n <= rst ? 0 : n + 1;

    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp_v);
        total++;
        if (got === exp_v) passed++;
        else $display("FAIL %s: got %h expected %h at edge %0d", t, got, exp_v, n);
    endtask

    function automatic int next_tick(input int x);
        return (x + TD - 1) / TD * TD;
    endfunction

    function automatic void push(input int at, input logic [12:0] ev, input string t);
        int   i;
        exp_t x;
        i = 0;
        while (i < q.size() && q[i].at < at) i++;
        if (i < q.size() && q[i].at == at) begin
            x = q[i];
            x.ev = x.ev | ev;
            q[i] = x;
        end else begin
            x.at = at;
            x.ev = ev;
            x.tag = t;
            q.insert(i, x);
        end
    endfunction

    function automatic void push_hold(input logic [N-1:0] m, input int p, input int lim);
        push(p, {1'b1, 9'b0, m}, "press");
        if (p + LONG_CLK < lim) push(p + LONG_CLK, {4'b0, m, 6'b0}, "long");
        for (int k = p + LONG_CLK + REP_CLK; k < lim; k += REP_CLK)
            push(k, {1'b0, m, 9'b0}, "repeat");
    endfunction

    task automatic wait_edge(input int target);
        while (n < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [N-1:0] v, output int e);
        @(posedge clk);
        #1;
        btn = v;
        e = n + 1;
    endtask

    task automatic hold_release(input logic [N-1:0] m, input int p, input int rel_off);
        int r, rr;
        r  = p + rel_off;
        rr = next_tick(r + 2) + (DEB - 1) * TD;
        push_hold(m, p, rr);
        push(rr, {7'b0, m, 3'b0}, "release");
        wait_edge(r - 1);
        btn = btn & ~m;
        wait_edge(rr + 12);
    endtask

    task automatic run_press(input logic [N-1:0] m, input int rel_off);
        int e, p;
        drive(btn | m, e);
        p = next_tick(e + 2) + (DEB - 1) * TD;
        hold_release(m, p, rel_off);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            obs   = {anyp, rpt, lng, rel, prs};
            obs_n = {anyp_n, rpt_n, lng_n, rel_n, prs_n};
            want  = '0;
            tag   = "idle";
            if (q.size() > 0 && q[0].at == n) begin
                ex   = q.pop_front();
                want = ex.ev;
                tag  = ex.tag;
            end
            if (obs != 0 || obs_n != 0 || want != 0) begin
                exp_lvl = (exp_lvl | want[2:0]) & ~want[5:3];
                check(tag, 32'(obs), 32'(want));
                check({tag, "_inv"}, 32'(obs_n), 32'(want));
                check({tag, "_level"}, 32'({lvl_n, lvl}), 32'({exp_lvl, exp_lvl}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e, p;
        passed  = 0;
        total   = 0;
        exp_lvl = '0;
        btn     = '0;
        rst     = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("reset_state", {all_out, all_out_n}, 32'h0);
        #1 rst = 1'b0;

        run_press(3'b001, 4);

        for (int i = 0; i < 12; i++) begin
            drive((i % 2 == 0) ? 3'b010 : 3'b000, e);
            repeat (4) @(posedge clk);
        end
        run_press(3'b010, 4);

        run_press(3'b001, 40);
        run_press(3'b001, 10);
        run_press(3'b101, 4);

        drive(3'b001, e);
        p = next_tick(e + 2) + (DEB - 1) * TD;
        push_hold(3'b001, p, p + LONG_CLK + REP_CLK + 3);
        wait_edge(p + LONG_CLK + REP_CLK + 2);
        #6 rst = 1'b1;
        #1 check("reset_clears", {all_out, all_out_n}, 32'h0);
        q.delete();
        exp_lvl = '0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        p = next_tick(1 + 2) + (DEB - 1) * TD;
        hold_release(3'b001, p, 30);

        check("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
